// File: rtl/rsp_ldbar32_seq_if.sv
// Write-load request channel: valid/ready handshake that carries
// a target register index or a broadcast flag.
interface rsp_ldbar32_seq_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic       wr_all;

  modport master (output wr_valid, output wr_addr, output wr_all, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_all, output wr_ready);
endinterface

// File: rtl/rsp_ldbar32_seq.sv
// Queues load requests in a 2-entry FIFO and issues them as one-cycle,
// active-low per-register load strobes, with hold and issue counting.
module rsp_ldbar32_seq (
  input  logic                    clk,
  input  logic                    reset,
  rsp_ldbar32_seq_if.slave        wr,
  input  logic                    ld_hold,
  output logic [31:0]             ld_bar,
  output logic                    ld_busy,
  output logic [7:0]              ld_cnt
);

  logic       fifo_all_reg  [2];
  logic [4:0] fifo_addr_reg [2];

  logic [1:0]  occ_reg, occ_next;
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [31:0] ld_bar_reg, ld_bar_next;
  logic [7:0]  ld_cnt_reg;

  logic        push, pop;
  logic        head_all;
  logic [4:0]  head_addr;
  logic [31:0] strobe_mask;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign wr.wr_ready = (occ_reg != 2'd2);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (occ_reg != 2'd0) && !ld_hold;

  assign head_all  = fifo_all_reg[rd_ptr_reg];
  assign head_addr = fifo_addr_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_strobe
      assign strobe_mask[gi] = !(head_all || (head_addr == 5'(gi)));
    end
  endgenerate

  always_comb begin
    occ_next    = occ_reg;
    ld_bar_next = 32'hFFFF_FFFF;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
    if (pop) begin
      ld_bar_next = strobe_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_reg    <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      ld_bar_reg <= 32'hFFFF_FFFF;
      ld_cnt_reg <= 8'd0;
    end else begin
      occ_reg    <= occ_next;
      ld_bar_reg <= ld_bar_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        ld_cnt_reg <= ld_cnt_reg + 8'd1;
      end
    end
  end

  // Entry storage needs no reset: pointers and occupancy gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_all_reg[wr_ptr_reg]  <= wr.wr_all;
      fifo_addr_reg[wr_ptr_reg] <= wr.wr_addr;
    end
  end

  assign ld_bar  = ld_bar_reg;
  assign ld_cnt  = ld_cnt_reg;
  assign ld_busy = (occ_reg != 2'd0) || (ld_bar_reg != 32'hFFFF_FFFF);

endmodule

// File: tb/tb_rsp_ldbar32_seq.sv
// Directed bench for rsp_ldbar32_seq with a strobe scoreboard checked
// on every falling edge.
module tb_rsp_ldbar32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_hold;
  logic [31:0] ld_bar;
  logic        ld_busy;
  logic [7:0]  ld_cnt;

  rsp_ldbar32_seq_if bus ();

  rsp_ldbar32_seq dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (bus.slave),
    .ld_hold (ld_hold),
    .ld_bar  (ld_bar),
    .ld_busy (ld_busy),
    .ld_cnt  (ld_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Any strobe seen must be the oldest outstanding expected one.
  always @(negedge clk) begin
    if (!reset && ld_bar !== 32'hFFFF_FFFF) begin
      if (sb.size() == 0)
        chk("spurious_strobe", ld_bar, 32'hFFFF_FFFF);
      else
        chk("sb_strobe", ld_bar, sb.pop_front());
    end
  end

  logic [31:0] exp_bar;

  initial begin
    reset        = 1'b1;
    ld_hold      = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_all   = 1'b0;
    #1;
    chk("rst_ld_bar", ld_bar, 32'hFFFF_FFFF);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_cnt", 32'(ld_cnt), 32'd0);
    repeat (3) tick();
    chk("rst_valid_ignored_bar", ld_bar, 32'hFFFF_FFFF);
    chk("rst_valid_ignored_busy", 32'(ld_busy), 32'd0);
    bus.wr_valid = 1'b0;
    reset        = 1'b0;
    chk("post_rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("post_rst_busy", 32'(ld_busy), 32'd0);
    tick();
    chk("post_rst_bar", ld_bar, 32'hFFFF_FFFF);

    // Single request, addr 5: two-edge latency, one-cycle strobe.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    sb.push_back(32'hFFFF_FFDF);
    tick();
    bus.wr_valid = 1'b0;
    chk("single_n_bar", ld_bar, 32'hFFFF_FFFF);
    chk("single_n_busy", 32'(ld_busy), 32'd1);
    tick();
    chk("single_n1_bar", ld_bar, 32'hFFFF_FFDF);
    chk("single_n1_cnt", 32'(ld_cnt), 32'd1);
    tick();
    chk("single_n2_bar", ld_bar, 32'hFFFF_FFFF);
    chk("single_n2_busy", 32'(ld_busy), 32'd0);

    // Broadcast.
    bus.wr_valid = 1'b1;
    bus.wr_all   = 1'b1;
    bus.wr_addr  = 5'd12;
    sb.push_back(32'h0000_0000);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_all   = 1'b0;
    tick();
    chk("bcast_bar", ld_bar, 32'h0000_0000);
    tick();
    chk("bcast_after_bar", ld_bar, 32'hFFFF_FFFF);
    chk("bcast_cnt", 32'(ld_cnt), 32'd2);

    // Full / stall: a third request while full must be dropped.
    ld_hold      = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd3;
    sb.push_back(32'hFFFF_FFF7);
    tick();
    bus.wr_addr  = 5'd7;
    sb.push_back(32'hFFFF_FF7F);
    tick();
    chk("full_ready", 32'(bus.wr_ready), 32'd0);
    chk("full_bar", ld_bar, 32'hFFFF_FFFF);
    chk("full_busy", 32'(ld_busy), 32'd1);
    bus.wr_addr  = 5'd9;
    tick();
    bus.wr_valid = 1'b0;
    chk("full_ready_held", 32'(bus.wr_ready), 32'd0);
    chk("hold_bar", ld_bar, 32'hFFFF_FFFF);
    ld_hold = 1'b0;
    tick();
    chk("stall_pop1_bar", ld_bar, 32'hFFFF_FFF7);
    chk("stall_pop1_ready", 32'(bus.wr_ready), 32'd1);
    tick();
    chk("stall_pop2_bar", ld_bar, 32'hFFFF_FF7F);
    tick();
    chk("stall_idle_bar", ld_bar, 32'hFFFF_FFFF);
    chk("stall_idle_busy", 32'(ld_busy), 32'd0);
    chk("stall_cnt", 32'(ld_cnt), 32'd4);

    // Streaming 0..31 with valid held high.
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.wr_addr = 5'(i);
      exp_bar = 32'h1 << i;
      sb.push_back(~exp_bar);
      tick();
      if (i >= 1) begin
        exp_bar = 32'h1 << (i - 1);
        chk("stream_bar", ld_bar, ~exp_bar);
      end
    end
    bus.wr_valid = 1'b0;
    tick();
    chk("stream_last_bar", ld_bar, 32'h7FFF_FFFF);
    tick();
    chk("stream_idle_bar", ld_bar, 32'hFFFF_FFFF);
    chk("stream_cnt", 32'(ld_cnt), 32'd36);
    chk("stream_busy", 32'(ld_busy), 32'd0);

    // Reset in the middle of a strobe with one entry still queued.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd0;
    sb.push_back(32'hFFFF_FFFE);
    tick();
    bus.wr_addr  = 5'd1;
    sb.push_back(32'hFFFF_FFFD);
    tick();
    bus.wr_valid = 1'b0;
    chk("midrst_pre_bar", ld_bar, 32'hFFFF_FFFE);
    chk("midrst_pre_busy", 32'(ld_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_bar", ld_bar, 32'hFFFF_FFFF);
    chk("midrst_busy", 32'(ld_busy), 32'd0);
    chk("midrst_cnt", 32'(ld_cnt), 32'd0);
    chk("midrst_ready", 32'(bus.wr_ready), 32'd1);
    sb.delete();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("midrst_after_bar", ld_bar, 32'hFFFF_FFFF);
    chk("midrst_after_busy", 32'(ld_busy), 32'd0);
    chk("midrst_after_cnt", 32'(ld_cnt), 32'd0);

    // Counter wrap over 256 pops.
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.wr_addr = 5'(i);
      exp_bar = 32'h1 << (i % 32);
      sb.push_back(~exp_bar);
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("wrap_cnt_255", 32'(ld_cnt), 32'd255);
    tick();
    chk("wrap_cnt_0", 32'(ld_cnt), 32'd0);
    chk("wrap_last_bar", ld_bar, 32'h7FFF_FFFF);
    tick();
    chk("wrap_idle_busy", 32'(ld_busy), 32'd0);

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsp_ldbar32_seq.md
RSP_LDBAR32_SEQ -- requirements
Module: rsp_ldbar32_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port wr_valid, input, 1 bit: a write-load request is present.
REQ-004 SHALL have port wr_ready, output, 1 bit: the block can accept a request this cycle.
REQ-005 SHALL have port wr_addr, input, 5 bits: target register index, 0..31.
REQ-006 SHALL have port wr_all, input, 1 bit: broadcast load of all 32 registers; wr_addr is ignored when set.
REQ-007 SHALL have port ld_hold, input, 1 bit: stall issue of load strobes.
REQ-008 SHALL have port ld_bar, output, 32 bits: active-low per-register load strobes, driven directly from flops.
REQ-009 SHALL have port ld_busy, output, 1 bit: the queue is non-empty or a strobe is active.
REQ-010 SHALL have port ld_cnt, output, 8 bits: count of issued load strobe cycles, wrapping.

Function
REQ-011 SHALL hold accepted requests {wr_all, wr_addr} in a 2-entry FIFO with an occupancy count of 0..2.
REQ-012 SHALL drive wr_ready combinationally as (occupancy != 2); it SHALL NOT depend on wr_valid or on a pop in the same cycle.
REQ-013 SHALL push on a rising edge when wr_valid and wr_ready are both 1; wr_valid while wr_ready=0 SHALL be ignored, with no state change.
REQ-014 SHALL pop the head on a rising edge when occupancy > 0 and ld_hold = 0, using pre-edge values.
REQ-015 SHALL, on the same edge as a pop with wr_all = 0, register ld_bar = all ones except bit wr_addr = 0.
REQ-016 SHALL, on the same edge as a pop with wr_all = 1, register ld_bar = 32'h00000000.
REQ-017 SHALL register ld_bar = 32'hFFFFFFFF on any edge with no pop, so each strobe lasts exactly one cycle; back-to-back pops SHALL give consecutive single-cycle strobes.
REQ-018 SHALL support a simultaneous push and pop: occupancy is unchanged and FIFO order is preserved. At occupancy 2 no push is possible, per REQ-012.
REQ-019 SHALL have a latency of exactly two edges with ld_hold low and the FIFO empty: accepted at edge N, ld_bar strobe visible from edge N+1 through edge N+2.
REQ-020 SHALL freeze the FIFO contents while ld_hold = 1, with ld_bar forced all ones on the next edge; pushes SHALL continue while not full.
REQ-021 SHALL increment ld_cnt by 1 on every pop and wrap 255 -> 0.
REQ-022 SHALL drive ld_busy combinationally as (occupancy != 0) OR (ld_bar != 32'hFFFFFFFF).
REQ-023 SHALL keep FIFO read and write pointers 1 bit wide, wrapping 1 -> 0.

Reset
REQ-024 SHALL, while reset = 1, asynchronously force ld_bar = 32'hFFFFFFFF, occupancy = 0, both pointers = 0 and ld_cnt = 0, so that no spurious load strobe is produced.
REQ-025 SHALL, with reset asserted mid-operation, discard queued requests and terminate any active strobe immediately, without waiting for a clock edge.
REQ-026 SHALL output wr_ready = 1 and ld_busy = 0 during reset and in the first cycle after reset deasserts.
REQ-027 SHALL ignore wr_valid while reset = 1.

Verification
REQ-028 SHALL be covered by a single-request test: with reset released and hold = 0, push addr = 5 at edge N -> ld_bar = 32'hFFFFFFDF for exactly one cycle after edge N+1, ld_cnt = 1, then ld_busy = 0.
REQ-029 SHALL be covered by a broadcast test: push wr_all = 1 -> one cycle of ld_bar = 32'h00000000, then all ones.
REQ-030 SHALL be covered by a full/stall test:
- hold = 1; push addr 3, then addr 7;
- check wr_ready = 0 and that a third request is ignored;
- release hold -> strobes for bit 3, then bit 7, on consecutive cycles; wr_ready returns to 1 after the first pop.
REQ-031 SHALL be covered by a streaming test: wr_valid held high for addr 0..31 in order with hold = 0 -> 32 consecutive single-bit strobes in order, no gaps after the first, ld_cnt = 32.
REQ-032 SHALL be covered by a reset-mid-strobe test: assert reset while ld_bar = 32'hFFFFFFFE with one entry queued -> ld_bar = 32'hFFFFFFFF before the next edge, and no strobe after reset release.
REQ-033 SHALL be covered by a counter-wrap test: 256 pops -> ld_cnt = 0.
